// File: rtl/lcd_pkg.sv
// Shared constants, state type and address-step helper for the HD44780
// write-bus monitor.
package lcd_pkg;

   localparam logic [7:0] CMD_CLEAR  = 8'h01;
   localparam logic [7:0] MASK_CLEAR = 8'hFF;
   localparam logic [7:0] CMD_HOME   = 8'h02;
   localparam logic [7:0] MASK_HOME  = 8'hFE;
   localparam logic [7:0] CMD_ENTRY  = 8'h04;
   localparam logic [7:0] MASK_ENTRY = 8'hFC;
   localparam logic [7:0] CMD_SETDD  = 8'h80;
   localparam logic [7:0] MASK_SETDD = 8'h80;

   localparam logic [7:0] CHAR_SPACE = 8'h20;

   localparam logic [6:0] LINE1_BASE = 7'h00;
   localparam logic [6:0] LINE2_BASE = 7'h40;
   localparam logic [6:0] LINE_LAST  = 7'h27;
   localparam logic [6:0] ADDR_END   = 7'h67;

   typedef enum logic {IDLE, CLEAR} state_e;

   // Two-line DDRAM map: lines hold 0x00-0x27 and 0x40-0x67.
   function automatic logic [6:0] next_addr(input logic [6:0] a,
                                            input logic       inc);
      if (inc) begin
         if (a == LINE_LAST) return LINE2_BASE;
         if (a >= ADDR_END)  return LINE1_BASE;
         return a + 7'd1;
      end
      if (a == LINE1_BASE) return ADDR_END;
      if (a == LINE2_BASE) return LINE_LAST;
      return a - 7'd1;
   endfunction

endpackage

// File: rtl/lcd_bus_monitor_sync2.sv
// Generic two-flop synchroniser for signals crossing into clk_i.
module lcd_bus_monitor_sync2 #(
   parameter int unsigned W = 1
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   logic [W-1:0] meta_q;
   logic [W-1:0] sync_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/lcd_bus_monitor.sv
// Passive HD44780 write-bus decoder keeping a 16x2 shadow of visible DDRAM
// and exposing it as a packed 256-bit character buffer.
module lcd_bus_monitor
   import lcd_pkg::*;
#(
   parameter int unsigned MIN_EN_HIGH = 2
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         lcd_en_i,
   input  logic         lcd_rs_i,
   input  logic         lcd_rw_i,
   input  logic [7:0]   lcd_data_i,
   output logic [255:0] mp_o,
   output logic [6:0]   addr_o,
   output logic         frame_o,
   output logic         busy_o,
   output logic         err_o
);

   localparam logic [3:0] MIN_L = 4'(MIN_EN_HIGH);

   logic [10:0] bus_s;
   logic        en_s, rs_s, rw_s;
   logic [7:0]  data_s;

   lcd_bus_monitor_sync2 #(.W(11)) u_sync (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .d_i    ({lcd_en_i, lcd_rs_i, lcd_rw_i, lcd_data_i}),
      .q_o    (bus_s)
   );

   assign {en_s, rs_s, rw_s, data_s} = bus_s;

   logic        en_q;
   logic [3:0]  cnt_q, cnt_d;
   state_e      state_q, state_d;
   logic [6:0]  addr_q, addr_d;
   logic        id_q, id_d;
   logic        err_q, err_d;
   logic        frame_q, frame_d;
   logic [4:0]  clr_q, clr_d;
   logic [7:0]  mem_q [32];
   logic        we;
   logic [4:0]  widx;
   logic [7:0]  wdat;
   logic        fall, too_short, strobe;

   assign fall      = en_q & ~en_s;
   assign too_short = fall & (cnt_q < MIN_L);
   assign strobe    = fall & ~too_short & ~rw_s;

   always_comb begin
      cnt_d = '0;
      if (en_s) cnt_d = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      id_d    = id_q;
      err_d   = err_q | too_short;
      frame_d = 1'b0;
      clr_d   = clr_q;
      we      = 1'b0;
      widx    = clr_q;
      wdat    = CHAR_SPACE;
      if (state_q == CLEAR) begin
         we    = 1'b1;
         clr_d = clr_q + 5'd1;
         if (clr_q == 5'd31) state_d = IDLE;
         if (strobe) err_d = 1'b1;
      end else if (strobe && rs_s) begin
         // Only 0x00-0x0F and 0x40-0x4F are visible.
         if (addr_q[5:4] == 2'b00) begin
            we      = 1'b1;
            widx    = {addr_q[6], addr_q[3:0]};
            wdat    = data_s;
            frame_d = (addr_q == 7'h4F);
         end
         addr_d = next_addr(addr_q, id_q);
      end else if (strobe) begin
         unique case (1'b1)
            (data_s & MASK_SETDD) == CMD_SETDD: addr_d = data_s[6:0];
            (data_s & MASK_ENTRY) == CMD_ENTRY: id_d = data_s[1];
            (data_s & MASK_HOME) == CMD_HOME:   addr_d = LINE1_BASE;
            (data_s & MASK_CLEAR) == CMD_CLEAR: begin
               state_d = CLEAR;
               clr_d   = '0;
               addr_d  = LINE1_BASE;
               id_d    = 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         en_q    <= 1'b0;
         cnt_q   <= '0;
         state_q <= IDLE;
         addr_q  <= LINE1_BASE;
         id_q    <= 1'b1;
         err_q   <= 1'b0;
         frame_q <= 1'b0;
         clr_q   <= '0;
      end else begin
         en_q    <= en_s;
         cnt_q   <= cnt_d;
         state_q <= state_d;
         addr_q  <= addr_d;
         id_q    <= id_d;
         err_q   <= err_d;
         frame_q <= frame_d;
         clr_q   <= clr_d;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < 32; i++) mem_q[i] <= CHAR_SPACE;
      end else if (we) begin
         mem_q[widx] <= wdat;
      end
   end

   for (genvar i = 0; i < 32; i++) begin : g_mp
      assign mp_o[255-8*i -: 8] = mem_q[i];
   end

   assign addr_o  = addr_q;
   assign frame_o = frame_q;
   assign busy_o  = (state_q == CLEAR);
   assign err_o   = err_q;

endmodule

// File: tb/tb_lcd_bus_monitor.sv
// Self-checking bench: randomized LCD bus writes against a behavioural
// shadow-DDRAM model.
module tb_lcd_bus_monitor;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         en = 1'b0, rs = 1'b0, rw = 1'b0;
   logic [7:0]   data = 8'h00;
   logic [255:0] mp;
   logic [6:0]   addr;
   logic         frame, busy, err;

   always #5 clk = ~clk;

   lcd_bus_monitor #(.MIN_EN_HIGH(3)) dut (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .lcd_en_i   (en),
      .lcd_rs_i   (rs),
      .lcd_rw_i   (rw),
      .lcd_data_i (data),
      .mp_o       (mp),
      .addr_o     (addr),
      .frame_o    (frame),
      .busy_o     (busy),
      .err_o      (err)
   );

   int errors = 0;
   int checks = 0;
   int frame_cnt = 0;
   int busy_cnt = 0;
   logic [7:0] frame_byte = 8'h00;

   always @(negedge clk) begin
      if (frame) begin
         frame_cnt  <= frame_cnt + 1;
         frame_byte <= mp[7:0];
      end
      if (busy) busy_cnt <= busy_cnt + 1;
   end

   // Behavioural model
   logic [7:0] m_mem [32];
   int         m_addr;
   bit         m_id;
   bit         m_err;
   localparam logic [255:0] ALL_SP = {32{8'h20}};

   function automatic logic [255:0] m_mp();
      logic [255:0] r;
      for (int i = 0; i < 32; i++) r[255-8*i -: 8] = m_mem[i];
      return r;
   endfunction

   function automatic int m_step(int a, bit inc);
      if (inc) begin
         if (a == 39) return 64;
         if (a >= 103) return 0;
         return a + 1;
      end
      if (a == 0) return 103;
      if (a == 64) return 39;
      return a - 1;
   endfunction

   task automatic m_reset();
      for (int i = 0; i < 32; i++) m_mem[i] = 8'h20;
      m_addr = 0;
      m_id = 1;
      m_err = 0;
   endtask

   task automatic m_apply(bit r, logic [7:0] d);
      int idx;
      if (r) begin
         idx = -1;
         if (m_addr < 16) idx = m_addr;
         else if (m_addr >= 64 && m_addr < 80) idx = m_addr - 48;
         if (idx >= 0) m_mem[idx] = d;
         m_addr = m_step(m_addr, m_id);
      end else if (d >= 8'h80) begin
         m_addr = int'(d) - 128;
      end else if (d >= 8'h08) begin
      end else if (d >= 8'h04) begin
         m_id = d[1];
      end else if (d >= 8'h02) begin
         m_addr = 0;
      end else if (d == 8'h01) begin
         for (int i = 0; i < 32; i++) m_mem[i] = 8'h20;
         m_addr = 0;
         m_id = 1;
      end
   endtask

   task automatic lcd_write(bit r, bit w, logic [7:0] d, int hi);
      @(negedge clk);
      rs = r; rw = w; data = d;
      repeat (2) @(negedge clk);
      en = 1'b1;
      repeat (hi) @(negedge clk);
      en = 1'b0;
      repeat (5) @(negedge clk);
   endtask

   task automatic wr(bit r, logic [7:0] d);
      lcd_write(r, 1'b0, d, 3);
      m_apply(r, d);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      m_reset();
      repeat (3) @(negedge clk);
      checks++;
      if (mp !== ALL_SP) begin
         errors++; $display("FAIL reset_mp got %h want %h", mp, ALL_SP);
      end
      checks++;
      if ({addr, frame, busy, err} !== 10'b0) begin
         errors++;
         $display("FAIL reset_flags got addr=%h f=%b b=%b e=%b want 0",
                  addr, frame, busy, err);
      end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_basic();
      wr(0, 8'h80); wr(1, "P"); wr(1, "C");
      checks++;
      if (mp[255:240] !== 16'h5043) begin
         errors++; $display("FAIL basic_pc got %h want 5043", mp[255:240]);
      end
      checks++;
      if (addr !== 7'h02) begin
         errors++; $display("FAIL basic_addr got %h want 02", addr);
      end
      checks++;
      if (mp !== m_mp()) begin
         errors++; $display("FAIL basic_mp got %h want %h", mp, m_mp());
      end
   endtask

   task automatic test_frame();
      int f0;
      f0 = frame_cnt;
      wr(0, 8'hCF); wr(1, 8'h41);
      checks++;
      if (mp[7:0] !== 8'h41) begin
         errors++; $display("FAIL frame_byte got %h want 41", mp[7:0]);
      end
      checks++;
      if (frame_cnt - f0 != 1) begin
         errors++; $display("FAIL frame_pulses got %0d want 1", frame_cnt - f0);
      end
      checks++;
      if (frame_byte !== 8'h41) begin
         errors++; $display("FAIL frame_align got %h want 41", frame_byte);
      end
      checks++;
      if (addr !== 7'h50) begin
         errors++; $display("FAIL frame_addr got %h want 50", addr);
      end
   endtask

   task automatic test_discard();
      wr(0, 8'hA7); wr(1, 8'h58); wr(1, 8'h59);
      checks++;
      if (mp[127:120] !== 8'h59) begin
         errors++; $display("FAIL disc_l2c0 got %h want 59", mp[127:120]);
      end
      checks++;
      if (addr !== 7'h41) begin
         errors++; $display("FAIL disc_addr got %h want 41", addr);
      end
      checks++;
      if (mp !== m_mp()) begin
         errors++; $display("FAIL disc_mp got %h want %h", mp, m_mp());
      end
   endtask

   task automatic test_decrement();
      wr(0, 8'h04); wr(0, 8'h80); wr(1, 8'h33);
      checks++;
      if (addr !== 7'h67 || mp[255:248] !== 8'h33) begin
         errors++; $display("FAIL dec_wrap0 got %h/%h want 67/33",
                            addr, mp[255:248]);
      end
      wr(0, 8'hC0); wr(1, 8'h34);
      checks++;
      if (addr !== 7'h27) begin
         errors++; $display("FAIL dec_wrap40 got %h want 27", addr);
      end
      wr(0, 8'h06); wr(0, 8'hE7); wr(1, 8'h36);
      checks++;
      if (addr !== 7'h00) begin
         errors++; $display("FAIL inc_wrap67 got %h want 00", addr);
      end
      wr(0, 8'hFF); wr(1, 8'h37);
      checks++;
      if (addr !== 7'h00 || mp !== m_mp()) begin
         errors++; $display("FAIL inc_wrap7f got %h want 00", addr);
      end
   endtask

   task automatic test_rw();
      logic [255:0] p;
      logic [6:0]   a;
      p = mp; a = addr;
      lcd_write(1, 1, 8'h77, 3);
      lcd_write(0, 1, 8'h01, 3);
      checks++;
      if (mp !== p || addr !== a || busy !== 1'b0) begin
         errors++; $display("FAIL rw_ignored got addr=%h busy=%b want %h/0",
                            addr, busy, a);
      end
   endtask

   task automatic test_random();
      logic [7:0] picks [10];
      logic [7:0] d;
      int op;
      picks = '{8'h80, 8'h8F, 8'h90, 8'hA7, 8'hBF, 8'hC0, 8'hCF, 8'hE7,
                8'hFF, 8'h80};
      for (int n = 0; n < 60; n++) begin
         op = $urandom_range(0, 7);
         case (op)
            0: wr(0, picks[$urandom_range(0, 9)]);
            1: wr(0, 8'h80 | 8'($urandom_range(0, 127)));
            2: wr(0, 8'h04 | 8'($urandom_range(0, 3)));
            3: wr(0, 8'h02 | 8'($urandom_range(0, 1)));
            4: wr(0, 8'($urandom_range(8, 63)));
            default: begin
               d = 8'($urandom);
               wr(1, d);
            end
         endcase
         checks++;
         if (addr !== 7'(m_addr)) begin
            errors++; $display("FAIL rand_addr[%0d] got %h want %h",
                               n, addr, 7'(m_addr));
         end
         checks++;
         if (mp !== m_mp()) begin
            errors++; $display("FAIL rand_mp[%0d] got %h want %h",
                               n, mp, m_mp());
         end
      end
      wr(0, 8'h06);
   endtask

   task automatic test_clear();
      int b0;
      checks++;
      if (err !== 1'b0) begin
         errors++; $display("FAIL pre_clear_err got %b want 0", err);
      end
      wr(0, 8'h80);
      for (int i = 0; i < 16; i++) wr(1, 8'h41 + 8'(i));
      wr(0, 8'hC0);
      for (int i = 0; i < 16; i++) wr(1, 8'h61 + 8'(i));
      checks++;
      if (mp !== m_mp()) begin
         errors++; $display("FAIL fill_mp got %h want %h", mp, m_mp());
      end
      b0 = busy_cnt;
      lcd_write(0, 0, 8'h01, 3);
      checks++;
      if (busy !== 1'b1) begin
         errors++; $display("FAIL clear_busy_on got %b want 1", busy);
      end
      lcd_write(1, 0, 8'h55, 3);
      m_apply(0, 8'h01);
      m_err = 1;
      repeat (40) @(negedge clk);
      checks++;
      if (busy_cnt - b0 != 32) begin
         errors++; $display("FAIL clear_busy_len got %0d want 32",
                            busy_cnt - b0);
      end
      checks++;
      if (mp !== m_mp() || addr !== 7'h00) begin
         errors++; $display("FAIL clear_mp got %h addr=%h want spaces/00",
                            mp, addr);
      end
      checks++;
      if (err !== 1'(m_err) || busy !== 1'b0) begin
         errors++; $display("FAIL clear_err got e=%b b=%b want 1/0", err, busy);
      end
   endtask

   task automatic test_reset_mid();
      wr(0, 8'h80); wr(1, 8'h4B); wr(1, 8'h4C);
      lcd_write(0, 0, 8'h01, 3);
      repeat (4) @(negedge clk);
      checks++;
      if (busy !== 1'b1) begin
         errors++; $display("FAIL mid_busy got %b want 1", busy);
      end
      rst_n = 1'b0;
      #1;
      m_reset();
      checks++;
      if (mp !== ALL_SP || {addr, frame, busy, err} !== 10'b0) begin
         errors++; $display("FAIL mid_reset got addr=%h b=%b e=%b want 0",
                            addr, busy, err);
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (busy !== 1'b0 || err !== 1'b0 || mp !== ALL_SP) begin
         errors++; $display("FAIL post_reset got b=%b e=%b want 0/0", busy, err);
      end
   endtask

   task automatic test_short();
      lcd_write(1, 0, 8'h41, 1);
      checks++;
      if (mp !== m_mp() || addr !== 7'h00) begin
         errors++; $display("FAIL short1_drop got addr=%h want 00", addr);
      end
      checks++;
      if (err !== 1'b1) begin
         errors++; $display("FAIL short1_err got %b want 1", err);
      end
      lcd_write(1, 0, 8'h42, 2);
      checks++;
      if (mp !== m_mp() || addr !== 7'h00) begin
         errors++; $display("FAIL short2_drop got addr=%h want 00", addr);
      end
      wr(1, 8'h43);
      checks++;
      if (mp[255:248] !== 8'h43 || addr !== 7'h01) begin
         errors++; $display("FAIL min_accept got %h/%h want 43/01",
                            mp[255:248], addr);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_frame();
      test_discard();
      test_decrement();
      test_rw();
      test_random();
      test_clear();
      test_reset_mid();
      test_short();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
